// File: rtl/step_dir_decoder_pkg.sv
// Shared definitions for the step/direction decoder: FSM state encoding,
// default sizing and the saturating error-counter helper.
package step_dir_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    localparam int DEF_W      = 4;
    localparam int DEF_LOCK_N = 2;

    // Error counter sticks at its maximum instead of wrapping back to zero.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/step_dir_decoder_step_classify.sv
// Combinational step classifier: compares the new count against the previous
// sample and flags +1 / -1 steps and the two wrap-around cases.
module step_classify
    import step_dir_decoder_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] num_in,
    output logic         good_up,
    output logic         good_dn,
    output logic         wrap_up_c,
    output logic         wrap_dn_c
);

    logic [W-1:0] delta;

    // Modular difference; +1 and all-ones (-1) are the only legal steps.
    always_comb begin
        delta     = num_in - prev;
        good_up   = (delta == W'(1));
        good_dn   = (delta == '1);
        wrap_up_c = good_up && (prev == '1);
        wrap_dn_c = good_dn && (prev == '0);
    end

endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction decoder: watches the value of an up/down counter, recovers
// its direction, detects illegal steps and tracks lock on a clean stream.
module step_dir_decoder
    import step_dir_decoder_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int LOCK_N = DEF_LOCK_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] num_in,
    output logic         dir,
    output logic         dir_valid,
    output logic         step_err,
    output logic         wrap_up,
    output logic         wrap_dn,
    output logic         locked,
    output logic [3:0]   err_cnt
);

    localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);

    state_t       state_q, state_d;
    logic [W-1:0] prev_q, prev_d;
    logic [3:0]   good_cnt_q, good_cnt_d;
    logic [3:0]   err_cnt_d;
    logic [3:0]   good_inc;
    logic         dir_d, dir_valid_d, step_err_d, wrap_up_d, wrap_dn_d, locked_d;
    logic         good_up, good_dn, wrap_up_c, wrap_dn_c, good;

    step_classify #(.W(W)) u_classify (
        .prev      (prev_q),
        .num_in    (num_in),
        .good_up   (good_up),
        .good_dn   (good_dn),
        .wrap_up_c (wrap_up_c),
        .wrap_dn_c (wrap_dn_c)
    );

    assign good     = good_up | good_dn;
    assign good_inc = good_cnt_q + 4'd1;

    // Next-state, counter and pulse decode for the sample taken this edge.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_cnt;
        dir_d       = dir;
        dir_valid_d = 1'b0;
        step_err_d  = 1'b0;
        wrap_up_d   = 1'b0;
        wrap_dn_d   = 1'b0;
        if (en) begin
            prev_d = num_in;
            if (state_q == IDLE) begin
                // First sample only seeds the reference value.
                good_cnt_d = 4'd0;
                state_d    = ACQUIRE;
            end else if (good) begin
                dir_d       = good_dn;
                dir_valid_d = 1'b1;
                wrap_up_d   = wrap_up_c;
                wrap_dn_d   = wrap_dn_c;
                case (state_q)
                    ACQUIRE: begin
                        good_cnt_d = good_inc;
                        if (good_inc >= LOCK_N_C) state_d = LOCKED;
                    end
                    LOST: begin
                        good_cnt_d = 4'd1;
                        state_d    = (LOCK_N == 1) ? LOCKED : ACQUIRE;
                    end
                    default: ;
                endcase
            end else begin
                step_err_d = 1'b1;
                case (state_q)
                    ACQUIRE: good_cnt_d = 4'd0;
                    LOCKED: begin
                        state_d    = LOST;
                        good_cnt_d = 4'd0;
                        err_cnt_d  = sat_inc4(err_cnt);
                    end
                    LOST:    err_cnt_d = sat_inc4(err_cnt);
                    default: ;
                endcase
            end
        end
        locked_d = (state_d == LOCKED);
    end

    // State, reference value, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            good_cnt_q <= 4'd0;
            err_cnt    <= 4'd0;
            dir        <= 1'b0;
            dir_valid  <= 1'b0;
            step_err   <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_cnt_q <= good_cnt_d;
            err_cnt    <= err_cnt_d;
            dir        <= dir_d;
            dir_valid  <= dir_valid_d;
            step_err   <= step_err_d;
            wrap_up    <= wrap_up_d;
            wrap_dn    <= wrap_dn_d;
            locked     <= locked_d;
        end
    end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench for step_dir_decoder: a driver feeds samples and pushes the
// reference model's expected outputs; a monitor pops and compares each cycle.
module tb_step_dir_decoder;

    localparam int W      = 4;
    localparam int M      = 16;
    localparam int LOCK_N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] num_in;
    logic         dir, dir_valid, step_err, wrap_up, wrap_dn, locked;
    logic [3:0]   err_cnt;

    typedef struct packed {
        logic       dir;
        logic       dv;
        logic       se;
        logic       wu;
        logic       wd;
        logic       lk;
        logic [3:0] ec;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;

    // Reference model state: behaviour expressed as a lock flag, a lost flag
    // and a run of consecutive good steps.
    bit   m_have, m_locked, m_lost, m_dir;
    int   m_prev, m_run, m_err;

    step_dir_decoder #(.W(W), .LOCK_N(LOCK_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .num_in    (num_in),
        .dir       (dir),
        .dir_valid (dir_valid),
        .step_err  (step_err),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d required %0d", nm, $time, act, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_dir_valid"}, dir_valid, 0);
        chk({tag, "_step_err"}, step_err, 0);
        chk({tag, "_wrap_up"}, wrap_up, 0);
        chk({tag, "_wrap_dn"}, wrap_dn, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic model_reset();
        m_have = 0; m_locked = 0; m_lost = 0; m_dir = 0;
        m_prev = 0; m_run = 0; m_err = 0;
    endtask

    // Apply one cycle of input and record what the DUT must show after the edge.
    task automatic apply(input bit e, input int v);
        exp_t x;
        int   d;
        en     = e;
        num_in = v[W-1:0];
        x      = '0;
        if (e) begin
            if (!m_have) begin
                m_have = 1;
                m_run  = 0;
            end else begin
                d = (v - m_prev + M) % M;
                if (d == 1 || d == M - 1) begin
                    m_dir = (d == M - 1);
                    x.dv  = 1;
                    x.wu  = (d == 1) && (m_prev == M - 1);
                    x.wd  = (d == M - 1) && (m_prev == 0);
                    if (!m_locked) begin
                        if (m_lost) begin
                            m_lost = 0;
                            m_run  = 1;
                        end else begin
                            m_run++;
                        end
                        m_locked = (m_run >= LOCK_N);
                    end
                end else begin
                    x.se = 1;
                    if (m_locked || m_lost) begin
                        m_locked = 0;
                        m_lost   = 1;
                        m_err    = (m_err < 15) ? m_err + 1 : 15;
                    end else begin
                        m_run = 0;
                    end
                end
            end
            m_prev = v % M;
        end
        x.dir = m_dir;
        x.lk  = m_locked;
        x.ec  = 4'(m_err);
        sb.push_back(x);
        mon_on = 1'b1;
    endtask

    task automatic drive(input bit e, input int v);
        @(negedge clk);
        apply(e, v);
    endtask

    // Asynchronous reset between edges, held across one edge with en=1.
    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_on = 1'b0;
        rst    = 1'b0;
        #1;
        chk_zero("async_reset");
        model_reset();
        @(negedge clk);
        en     = 1'b1;
        num_in = W'($urandom_range(0, M - 1));
        @(posedge clk);
        #1;
        chk_zero("held_reset");
        @(negedge clk);
        rst = 1'b1;
        apply(1'b1, $urandom_range(0, M - 1));
    endtask

    // Monitor: every cycle the DUT presents a result the scoreboard owes one.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (mon_on) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                x = sb.pop_front();
                chk("dir", dir, x.dir);
                chk("dir_valid", dir_valid, x.dv);
                chk("step_err", step_err, x.se);
                chk("wrap_up", wrap_up, x.wu);
                chk("wrap_dn", wrap_dn, x.wd);
                chk("locked", locked, x.lk);
                chk("err_cnt", err_cnt, x.ec);
            end
        end
    end

    initial begin
        int dir_seq[] = '{5, 6, -1, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, -1, -1,
                          0, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 4, 9, 10, 11};
        int err_seq[] = '{0, 1, 2, 2, 2, 2, 3, 4};
        int cur;
        int r;
        int v;
        bit e;

        rst    = 1'b0;
        en     = 1'b0;
        num_in = '0;
        model_reset();
        #3;
        chk_zero("reset_state");

        @(negedge clk);
        rst = 1'b1;
        apply(1'b0, 0);

        // Lock, wrap up, reverse, wrap down, error, reacquire.
        foreach (dir_seq[i]) begin
            if (dir_seq[i] < 0) drive(1'b0, $urandom_range(0, M - 1));
            else                drive(1'b1, dir_seq[i]);
        end

        // Constant value while lost: err_cnt must saturate.
        drive(1'b1, 2);
        for (int i = 0; i < 20; i++) drive(1'b1, 2);

        // Build up err_cnt=3 while locked, then reset mid-stream.
        do_reset();
        foreach (err_seq[i]) drive(1'b1, err_seq[i]);
        do_reset();

        // Randomised stream: mostly +/-1 with gaps, repeats and jumps.
        cur = 0;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r < 8)       v = (cur + 1) % M;
            else if (r < 16) v = (cur + M - 1) % M;
            else if (r == 16) v = cur;
            else             v = $urandom_range(0, M - 1);
            if (e) cur = v;
            else   v = $urandom_range(0, M - 1);
            drive(e, v);
        end

        drive(1'b0, 0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/step_dir_decoder.md
STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 SHALL have parameter W, default 4, giving the width of the monitored count value.
REQ-002 SHALL have parameter LOCK_N, default 2, giving the number of consecutive good steps needed to reach lock (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: num_in is sampled on the clock edge where en=1.
REQ-006 SHALL have port num_in, input, W bits: the count value emitted by the up/down counter.
REQ-007 SHALL have port dir, output, 1 bit: recovered direction; 0 means +1 and 1 means -1 (same encoding as the counter's inst).
REQ-008 SHALL have port dir_valid, output, 1 bit: one-cycle pulse marking dir as updated by a good step.
REQ-009 SHALL have port step_err, output, 1 bit: one-cycle pulse on a sampled step that is neither +1 nor -1.
REQ-010 SHALL have port wrap_up, output, 1 bit: one-cycle pulse on a good step from 2^W-1 to 0.
REQ-011 SHALL have port wrap_dn, output, 1 bit: one-cycle pulse on a good step from 0 to 2^W-1.
REQ-012 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-013 SHALL have port err_cnt, output, 4 bits: count of step errors detected in LOCKED or LOST, saturating.

Function
REQ-014 SHALL compute delta = (num_in - prev) mod 2^W on each sample taken in any state other than IDLE, where prev is the last sampled value.
REQ-015 SHALL classify delta as good-up when delta=1, good-down when delta=2^W-1, and error otherwise (delta=0 is an error).
REQ-016 SHALL update prev to num_in on every sample, whether the step is good or an error.
REQ-017 SHALL implement four FSM states: IDLE, ACQUIRE, LOCKED and LOST.
REQ-018 In IDLE, on the first sample the block SHALL store prev, clear good_cnt and move to ACQUIRE, with no pulses.
REQ-019 In ACQUIRE, a good step SHALL increment good_cnt, and when good_cnt reaches LOCK_N the FSM SHALL move to LOCKED.
REQ-020 In ACQUIRE, an error SHALL clear good_cnt and pulse step_err, with no change to err_cnt.
REQ-021 In LOCKED, a good step SHALL keep the FSM in LOCKED.
REQ-022 In LOCKED, an error SHALL move the FSM to LOST, pulse step_err and increment err_cnt.
REQ-023 In LOST, a good step SHALL set good_cnt=1 and move to ACQUIRE, or move directly to LOCKED when LOCK_N=1.
REQ-024 In LOST, an error SHALL keep the FSM in LOST, pulse step_err and increment err_cnt.
REQ-025 Every good step, in any state, SHALL set dir and pulse dir_valid.
REQ-026 wrap_up and wrap_dn SHALL pulse together with dir_valid only for the wrap transitions defined in REQ-010 and REQ-011.
REQ-027 All outputs SHALL be registered, with a latency of exactly 1 clock from the sampling edge to the pulse.
REQ-028 All pulses SHALL be low on every cycle without a sample, and dir SHALL hold its last value on those cycles.
REQ-029 err_cnt SHALL saturate at 15 and never wrap.
REQ-030 Direction reversals (+1 followed by -1) SHALL be treated as good steps and SHALL NOT cause errors.
REQ-031 en=0 cycles between samples SHALL NOT affect classification; the delta is always taken against the last sample.

Reset
REQ-032 Asserting rst=0 SHALL immediately force state=IDLE, prev=0, good_cnt=0, dir=0, dir_valid=0, step_err=0, wrap_up=0, wrap_dn=0, locked=0 and err_cnt=0.
REQ-033 Reset asserted mid-stream SHALL discard any partial lock, and the first sample after release SHALL be treated as an IDLE sample.
REQ-034 No sample SHALL be taken on a clock edge while rst=0.

Structure
REQ-035 A shared package/header SHALL hold the FSM state encodings (2 bits: IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3) and the default W and LOCK_N.
REQ-036 One combinational sub-module, step_classify, SHALL take prev and num_in and produce good_up, good_dn, wrap_up_c and wrap_dn_c.
REQ-037 The FSM, the counters and the output registers SHALL be in the top module.

Verification
REQ-038 Scenario: en=1 with the sequence 5,6,7,8 -> after the 3rd sample locked=1 (LOCK_N=2); dir=0 with dir_valid pulsing on samples 2-4; err_cnt=0.
REQ-039 Scenario: once locked, feed 14,15,0,1 -> wrap_up pulses 1 cycle after the sample of 0; locked stays 1.
REQ-040 Scenario: once locked, feed 1,0,15 -> dir=1 and wrap_dn pulses on 15; no step_err.
REQ-041 Scenario: once locked, feed 3,4,9,10,11 -> step_err on 9, locked=0 (LOST), err_cnt=1; 10 enters ACQUIRE and 11 relocks.
REQ-042 Scenario: 20 consecutive error samples (a constant value) in LOST -> err_cnt stops at 15; step_err pulses every sample.
REQ-043 Scenario: reset asserted asynchronously between clock edges while locked with err_cnt=3 -> all outputs zero immediately; the next sample after release produces no pulse.
